// File: rtl/clock_ctrl.sv
// Time-of-day controller: 1 Hz prescaler, chained sec/min/hour counters and a
// three-state set-mode FSM (RUN / SET_HR / SET_MIN) driven by two button pulses.
module clock_ctrl #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLINK_CYC = 12_500_000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iMode,
  input  logic       iInc,
  output logic [5:0] oSec,
  output logic [5:0] oMin,
  output logic [4:0] oHour,
  output logic [1:0] oMode,
  output logic       oBlink,
  output logic       oSecStrb,
  output logic       oDayStrb
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYC - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre;
  logic [BW-1:0] blink_cnt;
  logic          tick;
  logic          inc_hr;
  logic          inc_min;
  logic          to_run;
  logic          at_midnight_edge;

  // Wrap-around increments for the minute/second and hour counters.
  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  assign oMode = state;
  assign at_midnight_edge = (oSec == 6'd59) && (oMin == 6'd59) && (oHour == 5'd23);

  // State register.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state and per-cycle control decode. A mode press in RUN suppresses
  // that cycle's tick so a strobe never lands while already in a set state.
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    inc_hr    = 1'b0;
    inc_min   = 1'b0;
    to_run    = 1'b0;
    case (state)
      RUN: begin
        if (iMode) state_nxt = SET_HR;
        else       tick      = (pre == PRE_MAX);
      end
      SET_HR: begin
        if (iMode) state_nxt = SET_MIN;
        else       inc_hr    = iInc;
      end
      SET_MIN: begin
        if (iMode) begin
          state_nxt = RUN;
          to_run    = 1'b1;
        end else begin
          inc_min = iInc;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Prescaler: free-runs only in RUN, frozen in set modes, cleared on return to RUN.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      pre <= '0;
    end else if (to_run) begin
      pre <= '0;
    end else if (state == RUN && !iMode) begin
      pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
    end
  end

  // Time counters: tick-driven chain in RUN, single-field edits in set modes.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oSec  <= '0;
      oMin  <= '0;
      oHour <= '0;
    end else if (tick) begin
      oSec <= inc_mod60(oSec);
      if (oSec == 6'd59) begin
        oMin <= inc_mod60(oMin);
        if (oMin == 6'd59) oHour <= inc_mod24(oHour);
      end
    end else if (inc_hr) begin
      oHour <= inc_mod24(oHour);
    end else if (inc_min) begin
      oMin <= inc_mod60(oMin);
    end else if (to_run) begin
      oSec <= '0;
    end
  end

  // Strobes appear in the same cycle as the new seconds value.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oSecStrb <= 1'b0;
      oDayStrb <= 1'b0;
    end else begin
      oSecStrb <= tick;
      oDayStrb <= tick && at_midnight_edge;
    end
  end

  // Blink phase: restarts high on entering any set state, low in RUN.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oBlink    <= 1'b0;
      blink_cnt <= '0;
    end else if (state_nxt == RUN) begin
      oBlink    <= 1'b0;
      blink_cnt <= '0;
    end else if (state_nxt != state) begin
      oBlink    <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_MAX) begin
      oBlink    <= ~oBlink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

endmodule
